// File: rtl/instruction_fetch_ctrl.sv
// Instruction fetch sequencer. It owns the PC and drives a combinational-read
// instruction memory. Fetched words go into a 2-entry FIFO, and the FIFO head
// is presented to decode through a valid/ready handshake. A redirect flushes
// the FIFO and reloads the PC. Halt stops new fetches, but buffered words
// still drain.
module instruction_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [31:0] IMemAddress,
  input  logic [31:0] IMemInstruction,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutInstruction,
  output logic [31:0] OutPC,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  input  logic        Halt,
  output logic [31:0] FetchCount,
  output logic        MisalignedErr
);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0][31:0]  bins_q, bins_d;   // buffered instruction words, [0] is head
  logic [1:0][31:0]  bpc_q, bpc_d;     // matching fetch addresses
  logic [31:0]       fc_q, fc_d;
  logic              err_q, err_d;

  logic       pop, push, redir;
  logic [1:0] wr_idx;

  // Handshake and fetch qualifiers. A redirect pulse during BOOT is ignored.
  always_comb begin
    pop    = (cnt_q != 2'd0) && OutReady;
    redir  = Redirect && (state_q != BOOT);
    push   = (state_q == RUN) && !Halt && !Redirect && ((cnt_q != 2'd2) || pop);
    // The new entry goes in behind whatever survives this cycle's pop.
    wr_idx = cnt_q - {1'b0, pop};
  end

  // State transitions depend only on Halt. A redirect never changes the state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (Halt)  state_d = HALTED;
      HALTED:  if (!Halt) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Next-state logic for the PC, the FIFO, the handshake counter and the sticky error flag.
  always_comb begin
    pc_d   = pc_q;
    cnt_d  = cnt_q;
    bins_d = bins_q;
    bpc_d  = bpc_q;
    err_d  = err_q;
    fc_d   = pop ? fc_q + 32'd1 : fc_q;

    if (redir) begin
      cnt_d = 2'd0;
      pc_d  = {RedirectTarget[31:2], 2'b00};
      err_d = err_q | (RedirectTarget[1:0] != 2'b00);
    end else begin
      if (pop) begin
        bins_d[0] = bins_q[1];
        bpc_d[0]  = bpc_q[1];
      end
      if (push) begin
        bins_d[wr_idx[0]] = IMemInstruction;
        bpc_d[wr_idx[0]]  = pc_q;
        pc_d              = pc_q + 32'd4;
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // State registers. Reset has priority over everything, including a pending pop.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= 2'd0;
      bins_q  <= '0;
      bpc_q   <= '0;
      fc_q    <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      bins_q  <= bins_d;
      bpc_q   <= bpc_d;
      fc_q    <= fc_d;
      err_q   <= err_d;
    end
  end

  // The outputs come from registers only. The head is forced to zero while the FIFO is empty.
  always_comb begin
    IMemAddress    = pc_q;
    OutValid       = (cnt_q != 2'd0);
    OutInstruction = OutValid ? bins_q[0] : 32'd0;
    OutPC          = OutValid ? bpc_q[0]  : 32'd0;
    FetchCount     = fc_q;
    MisalignedErr  = err_q;
  end

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Bench for instruction_fetch_ctrl. It first runs a table of hand-computed
// scenario vectors, then a long randomized run checked against a queue-based
// behavioural model. The memory returns mem[i] = i*3.
module tb_instruction_fetch_ctrl;

  logic        Clk = 1'b0;
  logic        Reset, OutReady, Redirect, Halt;
  logic [31:0] RedirectTarget;
  logic [31:0] IMemAddress, IMemInstruction, OutInstruction, OutPC, FetchCount;
  logic        OutValid, MisalignedErr;

  int total = 0;
  int bad   = 0;

  instruction_fetch_ctrl #(.RESET_PC(32'h0)) dut (
    .Clk(Clk), .Reset(Reset),
    .IMemAddress(IMemAddress), .IMemInstruction(IMemInstruction),
    .OutValid(OutValid), .OutReady(OutReady),
    .OutInstruction(OutInstruction), .OutPC(OutPC),
    .Redirect(Redirect), .RedirectTarget(RedirectTarget), .Halt(Halt),
    .FetchCount(FetchCount), .MisalignedErr(MisalignedErr)
  );

  always #5 Clk = ~Clk;

  // The memory decodes address bits [10:2] only, so higher addresses alias.
  assign IMemInstruction = {23'd0, IMemAddress[10:2]} * 32'd3;

  // ---------------- behavioural model ----------------
  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc, m_fc;
  logic        m_err, m_boot, m_hprev;

  task automatic model_edge(input logic rst, rdy, redir, halt, input logic [31:0] tgt);
    bit   pop;
    int   left;
    ent_t e;
    if (rst) begin
      mq.delete(); m_pc = 32'h0; m_fc = 0; m_err = 0; m_boot = 1; m_hprev = 0;
    end else begin
      pop = (mq.size() != 0) && rdy;
      if (pop) m_fc = m_fc + 1;
      if (m_boot) begin
        m_boot = 0; m_hprev = 0;
      end else begin
        left = mq.size() - (pop ? 1 : 0);
        if (pop) void'(mq.pop_front());
        if (redir) begin
          mq.delete();
          m_pc = tgt & ~32'h3;
          if (tgt[1:0] != 2'b00) m_err = 1;
        end else if (!m_hprev && !halt && left < 2) begin
          e.pc  = m_pc;
          e.ins = {23'd0, m_pc[10:2]} * 32'd3;
          mq.push_back(e);
          m_pc = m_pc + 4;
        end
        m_hprev = halt;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs, clock it, and advance the model.
  task automatic cyc(input logic rst, rdy, redir, halt, input logic [31:0] tgt);
    Reset = rst; OutReady = rdy; Redirect = redir; Halt = halt; RedirectTarget = tgt;
    @(posedge Clk);
    model_edge(rst, rdy, redir, halt, tgt);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic rst, rdy, redir, halt; logic [31:0] tgt;
    logic v; logic [31:0] pc, ins, addr, fc; logic err;
  } vec_t;
  vec_t tbl[37];

  function automatic vec_t mk(logic rst, rdy, redir, halt, logic [31:0] tgt,
                              logic v, logic [31:0] pc, ins, addr, fc, logic err);
    vec_t r;
    r.rst = rst; r.rdy = rdy; r.redir = redir; r.halt = halt; r.tgt = tgt;
    r.v = v; r.pc = pc; r.ins = ins; r.addr = addr; r.fc = fc; r.err = err;
    return r;
  endfunction

  initial begin
    logic rr, rrdy, rred, rh;
    logic [31:0] rt;

    // Scenario: reset release, OutReady=1, 2-cycle start latency.
    tbl[0]  = mk(1,1,0,0,0,     0,0,0,0,0,0);
    tbl[1]  = mk(0,1,0,0,0,     0,0,0,0,0,0);
    tbl[2]  = mk(0,1,0,0,0,     1,'h0,'h0,'h4,0,0);
    tbl[3]  = mk(0,1,0,0,0,     1,'h4,'h3,'h8,1,0);
    tbl[4]  = mk(0,1,0,0,0,     1,'h8,'h6,'hC,2,0);
    tbl[5]  = mk(0,1,0,0,0,     1,'hC,'h9,'h10,3,0);
    // Scenario: backpressure for 5 cycles after the first valid.
    tbl[6]  = mk(1,0,0,0,0,     0,0,0,0,0,0);
    tbl[7]  = mk(0,0,0,0,0,     0,0,0,0,0,0);
    tbl[8]  = mk(0,0,0,0,0,     1,'h0,'h0,'h4,0,0);
    tbl[9]  = mk(0,0,0,0,0,     1,'h0,'h0,'h8,0,0);
    tbl[10] = mk(0,0,0,0,0,     1,'h0,'h0,'h8,0,0);
    tbl[11] = mk(0,0,0,0,0,     1,'h0,'h0,'h8,0,0);
    tbl[12] = mk(0,0,0,0,0,     1,'h0,'h0,'h8,0,0);
    tbl[13] = mk(0,0,0,0,0,     1,'h0,'h0,'h8,0,0);
    tbl[14] = mk(0,1,0,0,0,     1,'h4,'h3,'hC,1,0);
    tbl[15] = mk(0,1,0,0,0,     1,'h8,'h6,'h10,2,0);
    tbl[16] = mk(0,1,0,0,0,     1,'hC,'h9,'h14,3,0);
    // Scenario: redirect to 0x40 with a full buffer.
    tbl[17] = mk(0,0,0,0,0,     1,'hC,'h9,'h14,3,0);
    tbl[18] = mk(0,0,1,0,'h40,  0,0,0,'h40,3,0);
    tbl[19] = mk(0,1,0,0,0,     1,'h40,'h30,'h44,3,0);
    tbl[20] = mk(0,1,0,0,0,     1,'h44,'h33,'h48,4,0);
    tbl[21] = mk(0,0,0,0,0,     1,'h44,'h33,'h4C,4,0);
    // Scenario: halt for 4 cycles with 2 entries buffered, draining.
    tbl[22] = mk(0,1,0,1,0,     1,'h48,'h36,'h4C,5,0);
    tbl[23] = mk(0,1,0,1,0,     0,0,0,'h4C,6,0);
    tbl[24] = mk(0,1,0,1,0,     0,0,0,'h4C,6,0);
    tbl[25] = mk(0,1,0,1,0,     0,0,0,'h4C,6,0);
    tbl[26] = mk(0,1,0,0,0,     0,0,0,'h4C,6,0);
    tbl[27] = mk(0,1,0,0,0,     1,'h4C,'h39,'h50,6,0);
    tbl[28] = mk(0,1,0,0,0,     1,'h50,'h3C,'h54,7,0);
    // Scenario: misaligned redirect to 0x42 together with Halt.
    tbl[29] = mk(0,0,1,1,'h42,  0,0,0,'h40,7,1);
    tbl[30] = mk(0,1,0,0,0,     0,0,0,'h40,7,1);
    tbl[31] = mk(0,1,0,0,0,     1,'h40,'h30,'h44,7,1);
    tbl[32] = mk(0,0,0,0,0,     1,'h40,'h30,'h48,7,1);
    // Scenario: reset mid-stream with 2 entries buffered and OutReady=1.
    tbl[33] = mk(1,1,0,0,0,     0,0,0,0,0,0);
    tbl[34] = mk(0,1,0,0,0,     0,0,0,0,0,0);
    tbl[35] = mk(0,1,0,0,0,     1,'h0,'h0,'h4,0,0);
    tbl[36] = mk(0,1,0,0,0,     1,'h4,'h3,'h8,1,0);

    for (int i = 0; i < 37; i++) begin
      cyc(tbl[i].rst, tbl[i].rdy, tbl[i].redir, tbl[i].halt, tbl[i].tgt);
      chk($sformatf("row%0d valid", i), {31'd0, OutValid},      {31'd0, tbl[i].v});
      chk($sformatf("row%0d pc",    i), OutPC,                  tbl[i].pc);
      chk($sformatf("row%0d instr", i), OutInstruction,         tbl[i].ins);
      chk($sformatf("row%0d addr",  i), IMemAddress,            tbl[i].addr);
      chk($sformatf("row%0d fcnt",  i), FetchCount,             tbl[i].fc);
      chk($sformatf("row%0d err",   i), {31'd0, MisalignedErr}, {31'd0, tbl[i].err});
    end

    // Randomized run against the model.
    cyc(1, 0, 0, 0, 0);
    rh = 0;
    for (int n = 0; n < 3000; n++) begin
      rr   = ($urandom_range(0, 149) == 0);
      rrdy = ($urandom_range(0, 3) != 0);
      rred = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 7) == 0) rh = ~rh;
      rt   = ($urandom_range(0, 7) == 0) ? $urandom() : ($urandom() & 32'h0000_0FFC);
      if ($urandom_range(0, 9) == 0) rt[1:0] = 2'($urandom_range(1, 3));
      cyc(rr, rrdy, rred, rh, rt);
      chk($sformatf("rnd%0d valid", n), {31'd0, OutValid}, {31'd0, mq.size() != 0});
      chk($sformatf("rnd%0d pc",    n), OutPC,          (mq.size() != 0) ? mq[0].pc  : 32'd0);
      chk($sformatf("rnd%0d instr", n), OutInstruction, (mq.size() != 0) ? mq[0].ins : 32'd0);
      chk($sformatf("rnd%0d addr",  n), IMemAddress, m_pc);
      chk($sformatf("rnd%0d fcnt",  n), FetchCount,  m_fc);
      chk($sformatf("rnd%0d err",   n), {31'd0, MisalignedErr}, {31'd0, m_err});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
